// File: rtl/dot_layer_if.sv
// dot_layer_sched_if
// Bundles the scheduler's datapath and result-handshake signals.
//   load      scheduler -> datapath   load/enable for one dot-channel pass
//   cs        scheduler -> weights    chunk select
//   dc_valid  datapath  -> scheduler  result valid
//   dc_q      datapath  -> scheduler  result value
//   res_valid scheduler -> downstream captured result is presented
//   res_ready downstream -> scheduler result accepted when high with res_valid
//   res_data  scheduler -> downstream captured result
//   res_ch    scheduler -> downstream channel index of res_data
// master = scheduler side, slave = datapath/downstream side.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

interface dot_layer_sched_if #(
    parameter int DW = `DATA_LEN
) ();
    logic          load;
    logic [3:0]    cs;
    logic          dc_valid;
    logic [DW-1:0] dc_q;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [4:0]    res_ch;

    modport master (
        output load, cs, res_valid, res_data, res_ch,
        input  dc_valid, dc_q, res_ready
    );

    modport slave (
        input  load, cs, res_valid, res_data, res_ch,
        output dc_valid, dc_q, res_ready
    );
endinterface

// File: rtl/dot_layer_sched.sv
// dot_layer_sched
// Sequences one layer run over NUM_CH output channels. For each channel it
// holds load low for one cycle, then raises load and steps the chunk select
// 0..NUM_CHUNK-1 until the datapath reports a result, which is captured and
// offered downstream with a valid/ready handshake. A watchdog aborts the
// run with an err pulse if the datapath stays silent for TIMEOUT cycles.
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a run (sampled in IDLE only)
//   abort  in   synchronous cancel of a run in progress
//   busy   out  high in every state except IDLE
//   done   out  one-cycle pulse after the last channel's result is accepted
//   err    out  one-cycle pulse on watchdog timeout
//   bus    master side of dot_layer_sched_if (load, cs, dc_*, res_*)
//
// state | meaning
// IDLE  | waiting for start, load=0, cs=0
// GAP   | one load-low cycle so the datapath always sees a 0->1 load edge
// RUN   | load=1, cs stepping 0..NUM_CHUNK-1
// HOLD  | load=1, cs parked at NUM_CHUNK-1, waiting for dc_valid
// OUT   | result presented, waiting for res_ready
// FIN   | done pulse, back to IDLE
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module dot_layer_sched #(
    parameter int NUM_CH    = 24,
    parameter int NUM_CHUNK = 12,
    parameter int DW        = `DATA_LEN,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    dot_layer_sched_if.master      bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        OUT  = 3'd4,
        FIN  = 3'd5
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0]    CS_LAST = 4'(NUM_CHUNK - 1);
    localparam logic [4:0]    CH_LAST = 5'(NUM_CH - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    state_t        state;
    logic [4:0]    ch;
    logic [TW-1:0] tcnt;

    logic          load_r;
    logic [3:0]    cs_r;
    logic          res_valid_r;
    logic [DW-1:0] res_data_r;
    logic [4:0]    res_ch_r;

    assign bus.load      = load_r;
    assign bus.cs        = cs_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_ch    = res_ch_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= '0;
            tcnt        <= '0;
            load_r      <= 1'b0;
            cs_r        <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_ch_r    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Abort outranks a same-cycle dc_valid and a same-cycle handshake.
            if (abort && state != IDLE) begin
                state       <= IDLE;
                ch          <= '0;
                tcnt        <= '0;
                load_r      <= 1'b0;
                cs_r        <= '0;
                res_valid_r <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= GAP;
                            ch    <= '0;
                            busy  <= 1'b1;
                        end
                    end

                    GAP: begin
                        state  <= RUN;
                        load_r <= 1'b1;
                        cs_r   <= '0;
                        tcnt   <= '0;
                    end

                    RUN, HOLD: begin
                        if (bus.dc_valid) begin
                            state       <= OUT;
                            load_r      <= 1'b0;
                            cs_r        <= '0;
                            res_valid_r <= 1'b1;
                            res_data_r  <= bus.dc_q;
                            res_ch_r    <= ch;
                        end else if (tcnt == T_LAST) begin
                            state  <= IDLE;
                            load_r <= 1'b0;
                            cs_r   <= '0;
                            ch     <= '0;
                            tcnt   <= '0;
                            busy   <= 1'b0;
                            err    <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                            // cs parks on the last chunk; HOLD simply keeps it there.
                            if (state == RUN) begin
                                if (cs_r == CS_LAST) begin
                                    state <= HOLD;
                                end else begin
                                    cs_r <= cs_r + 4'd1;
                                end
                            end
                        end
                    end

                    OUT: begin
                        if (bus.res_ready) begin
                            res_valid_r <= 1'b0;
                            if (ch == CH_LAST) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                ch    <= ch + 5'd1;
                                state <= GAP;
                            end
                        end
                    end

                    FIN: begin
                        state <= IDLE;
                        ch    <= '0;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state       <= IDLE;
                        load_r      <= 1'b0;
                        cs_r        <= '0;
                        res_valid_r <= 1'b0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dot_layer_sched.sv
module tb_dot_layer_sched;

    localparam int NUM_CH    = 4;
    localparam int NUM_CHUNK = 12;
    localparam int DW        = 16;
    localparam int TIMEOUT   = 64;

    localparam int K_RES  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, err;

    dot_layer_sched_if #(.DW(DW)) bus ();

    dot_layer_sched #(
        .NUM_CH   (NUM_CH),
        .NUM_CHUNK(NUM_CHUNK),
        .DW       (DW),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .busy (busy),
        .done (done),
        .err  (err),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
        logic [4:0]    ch;
    } item_t;

    item_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (what should be visible each cycle) -------
    int c = 0;
    bit m_busy = 0, m_win = 0, m_out = 0;
    int m_ch = 0, m_k = 0, m_lat = 0;
    int rise_at = -1, idle_at = -1;
    bit ev_win_off = 0, ev_out_on = 0, ev_out_off = 0, ev_busy_on = 0, ev_busy_off = 0;

    bit start_req = 0, abort_req = 0, spur_en = 0;
    int ready_pct = 100, lat_lo = 12, lat_hi = 12;

    task automatic push(input int kind, input logic [DW-1:0] data, input int chn);
        item_t it;
        it.kind = kind;
        it.data = data;
        it.ch   = 5'(chn);
        q.push_back(it);
    endtask

    task automatic model_clear();
        m_busy = 0; m_win = 0; m_out = 0; m_ch = 0; m_k = 0;
        rise_at = -1; idle_at = -1;
        ev_win_off = 0; ev_out_on = 0; ev_out_off = 0; ev_busy_on = 0; ev_busy_off = 0;
        start_req = 0; abort_req = 0;
        q.delete();
    endtask

    task automatic cycle();
        int exp_cs;
        @(posedge clk);
        #1;
        c++;
        if (ev_win_off)  m_win  = 0;
        if (ev_out_on)   m_out  = 1;
        if (ev_out_off)  m_out  = 0;
        if (ev_busy_on)  m_busy = 1;
        if (ev_busy_off) m_busy = 0;
        ev_win_off = 0; ev_out_on = 0; ev_out_off = 0; ev_busy_on = 0; ev_busy_off = 0;
        if (m_win) m_k++;
        if (c == rise_at) begin
            m_win   = 1;
            m_k     = 1;
            m_lat   = $urandom_range(lat_hi, lat_lo);
            rise_at = -1;
        end
        if (c == idle_at) begin
            m_busy  = 0;
            idle_at = -1;
        end

        chk("busy", busy, m_busy);
        chk("load", bus.load, m_win);
        chk("res_valid", bus.res_valid, m_out);
        if (m_win) begin
            exp_cs = (m_k - 1 < NUM_CHUNK - 1) ? m_k - 1 : NUM_CHUNK - 1;
            chk("cs_seq", bus.cs, exp_cs);
        end
        if (!m_busy) chk("cs_idle", bus.cs, 0);

        start     = start_req;
        abort     = abort_req;
        start_req = 0;
        abort_req = 0;
        bus.dc_q  = DW'($urandom);
        if (m_win) bus.dc_valid = (m_k == m_lat);
        else       bus.dc_valid = spur_en && ($urandom_range(2, 0) == 0);
        bus.res_ready = ($urandom_range(100, 1) <= ready_pct);

        if (abort && m_busy) begin
            q.delete();
            ev_win_off = 1; ev_out_off = 1; ev_busy_off = 1;
            rise_at = -1; idle_at = -1;
        end else begin
            if (m_out && bus.res_ready) begin
                ev_out_off = 1;
                if (m_ch < NUM_CH - 1) begin
                    m_ch++;
                    rise_at = c + 2;
                end else begin
                    push(K_DONE, '0, 0);
                    idle_at = c + 2;
                end
            end
            if (m_win && bus.dc_valid) begin
                push(K_RES, bus.dc_q, m_ch);
                ev_win_off = 1;
                ev_out_on  = 1;
            end else if (m_win && m_k == TIMEOUT) begin
                push(K_ERR, '0, 0);
                ev_win_off  = 1;
                ev_busy_off = 1;
            end
        end
        if (start && !m_busy) begin
            ev_busy_on = 1;
            m_ch       = 0;
            rise_at    = c + 2;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        item_t it;
        if (rst_n) begin
            if (bus.res_valid && bus.res_ready && !abort) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_res: result ch %0d data %0d accepted, nothing expected", bus.res_ch, bus.res_data);
                end else begin
                    it = q.pop_front();
                    chk("sb_res_kind", K_RES, it.kind);
                    chk("sb_res_data", bus.res_data, it.data);
                    chk("sb_res_ch", bus.res_ch, it.ch);
                end
            end
            if (done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_done: done pulse seen, nothing expected");
                end else begin
                    it = q.pop_front();
                    chk("sb_done_kind", K_DONE, it.kind);
                end
            end
            if (err) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_err: err pulse seen, nothing expected");
                end else begin
                    it = q.pop_front();
                    chk("sb_err_kind", K_ERR, it.kind);
                end
            end
        end
    end

    // ---------------- sequences ----------------
    task automatic run_layer(input int max_cyc, input bit fin_probe, input bit noisy_start);
        bit finished = 0;
        start_req = 1;
        cycle();
        for (int i = 0; i < max_cyc; i++) begin
            cycle();
            if (fin_probe && idle_at == c + 2) start_req = 1;
            if (noisy_start && m_busy && idle_at == -1 && $urandom_range(7, 0) == 0) start_req = 1;
            if (!m_busy && !ev_busy_on) begin
                finished = 1;
                break;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL run_bound: layer run exceeded %0d cycles", max_cyc);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_load"}, bus.load, 0);
        chk({tag, "_cs"}, bus.cs, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_res_ch"}, bus.res_ch, 0);
    endtask

    initial begin
        bus.dc_valid  = 0;
        bus.dc_q      = '0;
        bus.res_ready = 1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        #2;
        rst_n = 1;
        idle_cycles(3);

        // back-to-back channels at minimum period, start poked in the FIN cycle
        lat_lo = NUM_CHUNK; lat_hi = NUM_CHUNK; ready_pct = 100; spur_en = 0;
        run_layer(200, 1, 0);
        idle_cycles(3);

        // downstream stalls for 5 cycles with a result presented
        ready_pct = 0;
        start_req = 1;
        for (int i = 0; i < 60 && !m_out; i++) cycle();
        chk("stall_reached_out", m_out, 1);
        idle_cycles(5);
        ready_pct = 100;
        for (int i = 0; i < 200 && m_busy; i++) cycle();
        idle_cycles(2);

        // randomized latency, backpressure, stray dc_valid and ignored starts
        spur_en = 1; ready_pct = 60; lat_lo = 1; lat_hi = 20;
        for (int r = 0; r < 3; r++) begin
            run_layer(400, 0, 1);
            idle_cycles($urandom_range(3, 1));
        end
        spur_en = 0; ready_pct = 100;

        // dc_valid on the very last watchdog cycle still counts as a result
        lat_lo = TIMEOUT; lat_hi = TIMEOUT;
        run_layer(400, 0, 0);
        idle_cycles(2);

        // datapath never answers: watchdog fires
        lat_lo = TIMEOUT + 5; lat_hi = TIMEOUT + 5;
        run_layer(200, 0, 0);
        idle_cycles(4);

        // abort at cs=5 of channel 3, then a clean restart
        lat_lo = 12; lat_hi = 20;
        start_req = 1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (m_ch == 3 && m_win && m_k == 5) begin
                abort_req = 1;
                cycle();
                chk("abort_at_cs", bus.cs, 5);
                break;
            end
        end
        idle_cycles(2);
        run_layer(300, 0, 0);
        idle_cycles(2);

        // abort outranks a same-cycle handshake in OUT
        start_req = 1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (ev_out_on && m_ch == 1) begin
                abort_req = 1;
                cycle();
                break;
            end
        end
        idle_cycles(3);

        // reset between edges while parked in HOLD
        lat_lo = 40; lat_hi = 40;
        start_req = 1;
        for (int i = 0; i < 100 && !(m_win && m_k == 16); i++) cycle();
        chk("hold_reached_cs", bus.cs, NUM_CHUNK - 1);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check_reset_outputs("async_rst");
        model_clear();
        start = 0;
        abort = 0;
        @(negedge clk);
        #2;
        rst_n = 1;
        idle_cycles(3);
        lat_lo = 5; lat_hi = 15;
        run_layer(300, 0, 1);
        idle_cycles(3);

        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
